// File: rtl/sd_pkg.sv
// sd_pkg: shared types and helpers for the sequential signed divider.
// State encoding, the state enum and a width-generic magnitude helper
// (operands up to MAX_W bits).
package sd_pkg;

  localparam int unsigned MAX_W = 32;

  localparam logic [2:0] ENC_IDLE   = 3'd0;
  localparam logic [2:0] ENC_LOAD   = 3'd1;
  localparam logic [2:0] ENC_DIVIDE = 3'd2;
  localparam logic [2:0] ENC_FIXUP  = 3'd3;
  localparam logic [2:0] ENC_DONE   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = ENC_IDLE,
    S_LOAD   = ENC_LOAD,
    S_DIVIDE = ENC_DIVIDE,
    S_FIXUP  = ENC_FIXUP,
    S_DONE   = ENC_DONE
  } sd_state_t;

  localparam logic [MAX_W-1:0] ONE_MAX = 32'd1;

  // Unsigned magnitude of a two's-complement value held in the low 'width'
  // bits of val. The most-negative value maps to 2^(width-1) exactly.
  function automatic logic [MAX_W-1:0] abs_mag(input logic [MAX_W-1:0] val,
                                               input int unsigned   width);
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] neg;
    logic [MAX_W-1:0] sh;
    mask = (width >= MAX_W) ? '1 : ((ONE_MAX << width) - ONE_MAX);
    neg  = (~val + ONE_MAX) & mask;
    sh   = val >> (width - 32'd1);
    return sh[0] ? neg : (val & mask);
  endfunction

endpackage

// File: rtl/sd_restore_step.sv
// sd_restore_step: one combinational restoring-division iteration.
// Shifts the partial remainder left with the next dividend bit, trial-
// subtracts the divisor magnitude and restores when the result is negative.
module sd_restore_step #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] dvs_mag,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  // Trial subtract with one guard bit; the guard's sign decides restore.
  always_comb begin
    shifted = {rem_in, dvd_bit};
    diff    = shifted - {2'b00, dvs_mag};
    q_bit   = ~diff[WIDTH+1];
    rem_out = q_bit ? diff[WIDTH:0] : shifted[WIDTH:0];
  end

endmodule

// File: rtl/sd_divider.sv
// sd_divider: sequential signed integer divider, one quotient bit per clock,
// restoring algorithm with sign-magnitude pre/post processing.
// Optional macro SD_UNSIGNED_SUPPORT_EN adds port signed_in; when low the
// operands are treated as unsigned.
module sd_divider
  import sd_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset_in,
  input  logic             start_in,
`ifdef SD_UNSIGNED_SUPPORT_EN
  input  logic             signed_in,
`endif
  input  logic [WIDTH-1:0] dividend_in,
  input  logic [WIDTH-1:0] divisor_in,
  output logic [WIDTH-1:0] quotient_out,
  output logic [WIDTH-1:0] remainder_out,
  output logic             busy_out,
  output logic             done_out,
  output logic             overflow_out,
  output logic             div_by_zero_out
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  sd_state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;         // dividend as captured
  logic [WIDTH-1:0] b_q, b_d;         // divisor as captured
  logic             mode_q, mode_d;   // 1 = signed operation
  logic             sgn_q_q, sgn_q_d; // quotient sign
  logic             sgn_r_q, sgn_r_d; // remainder sign
  logic [WIDTH-1:0] dvd_q, dvd_d;     // dividend magnitude, shifted out MSB first
  logic [WIDTH-1:0] dvs_q, dvs_d;     // divisor magnitude
  logic [WIDTH:0]   rem_q, rem_d;     // partial remainder
  logic [WIDTH-1:0] quo_q, quo_d;     // quotient magnitude
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] qout_q, qout_d;
  logic [WIDTH-1:0] rout_q, rout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;
  logic             dz_q, dz_d;

  logic             mode_in;
  logic [MAX_W-1:0] ext_a, ext_b, abs_a, abs_b;
  logic [WIDTH:0]   step_rem;
  logic             step_bit;

`ifdef SD_UNSIGNED_SUPPORT_EN
  assign mode_in = signed_in;
`else
  assign mode_in = 1'b1;
`endif

  // Zero-extend captured operands into the helper's fixed width.
  always_comb begin
    ext_a = '0;
    ext_b = '0;
    ext_a[WIDTH-1:0] = a_q;
    ext_b[WIDTH-1:0] = b_q;
  end

  assign abs_a = abs_mag(ext_a, WIDTH);
  assign abs_b = abs_mag(ext_b, WIDTH);

  if (WIDTH < MAX_W) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^{abs_a[MAX_W-1:WIDTH], abs_b[MAX_W-1:WIDTH]};
  end

  sd_restore_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_q),
    .dvd_bit (dvd_q[WIDTH-1]),
    .dvs_mag (dvs_q),
    .rem_out (step_rem),
    .q_bit   (step_bit)
  );

  // State register.
  always_ff @(posedge clock or negedge reset_in) begin
    if (!reset_in) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_in) state_d = S_LOAD;
      S_LOAD:   state_d = (b_q == '0) ? S_FIXUP : S_DIVIDE;
      S_DIVIDE: if (cnt_q == CNT_LAST) state_d = S_FIXUP;
      S_FIXUP:  state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values per state.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    mode_d  = mode_q;
    sgn_q_d = sgn_q_q;
    sgn_r_d = sgn_r_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    qout_d  = qout_q;
    rout_d  = rout_q;
    busy_d  = busy_q;
    done_d  = done_q;
    ovf_d   = ovf_q;
    dz_d    = dz_q;
    case (state_q)
      S_IDLE: begin
        if (start_in) begin
          a_d    = dividend_in;
          b_d    = divisor_in;
          mode_d = mode_in;
          busy_d = 1'b1;
        end
      end
      S_LOAD: begin
        sgn_q_d = mode_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        sgn_r_d = mode_q & a_q[WIDTH-1];
        dvd_d   = mode_q ? abs_a[WIDTH-1:0] : a_q;
        dvs_d   = mode_q ? abs_b[WIDTH-1:0] : b_q;
        rem_d   = '0;
        quo_d   = '0;
        cnt_d   = '0;
      end
      S_DIVIDE: begin
        rem_d = step_rem;
        quo_d = {quo_q[WIDTH-2:0], step_bit};
        dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + CNT_ONE;
      end
      S_FIXUP: begin
        done_d = 1'b1;
        if (b_q == '0) begin
          dz_d   = 1'b1;
          ovf_d  = 1'b0;
          qout_d = '1;
          rout_d = a_q;
        end else begin
          dz_d   = 1'b0;
          ovf_d  = mode_q & ~sgn_q_q & quo_q[WIDTH-1];
          qout_d = sgn_q_q ? -quo_q : quo_q;
          rout_d = sgn_r_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
          if (ovf_d) begin
            qout_d = MIN_VAL;
            rout_d = '0;
          end
        end
      end
      S_DONE: begin
        done_d = 1'b0;
        busy_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clock or negedge reset_in) begin
    if (!reset_in) begin
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= 1'b0;
      sgn_q_q <= 1'b0;
      sgn_r_q <= 1'b0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      qout_q  <= '0;
      rout_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
      sgn_q_q <= sgn_q_d;
      sgn_r_q <= sgn_r_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      qout_q  <= qout_d;
      rout_q  <= rout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
    end
  end

  assign quotient_out    = qout_q;
  assign remainder_out   = rout_q;
  assign busy_out        = busy_q;
  assign done_out        = done_q;
  assign overflow_out    = ovf_q;
  assign div_by_zero_out = dz_q;

endmodule

// File: tb/tb_sd_divider.sv
// tb_sd_divider: scoreboard bench for sd_divider at WIDTH=16.
module tb_sd_divider;

  localparam int unsigned W = 16;

  logic         clock = 1'b0;
  logic         reset_in;
  logic         start_in;
  logic [W-1:0] dividend_in;
  logic [W-1:0] divisor_in;
  logic [W-1:0] quotient_out;
  logic [W-1:0] remainder_out;
  logic         busy_out;
  logic         done_out;
  logic         overflow_out;
  logic         div_by_zero_out;
`ifdef SD_UNSIGNED_SUPPORT_EN
  logic         signed_in = 1'b1;
`endif

  sd_divider #(.WIDTH(W)) dut (
    .clock           (clock),
    .reset_in        (reset_in),
    .start_in        (start_in),
`ifdef SD_UNSIGNED_SUPPORT_EN
    .signed_in       (signed_in),
`endif
    .dividend_in     (dividend_in),
    .divisor_in      (divisor_in),
    .quotient_out    (quotient_out),
    .remainder_out   (remainder_out),
    .busy_out        (busy_out),
    .done_out        (done_out),
    .overflow_out    (overflow_out),
    .div_by_zero_out (div_by_zero_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         ovf;
    logic         dz;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
    exp_t e;
    int   ia, ib;
    ia = a;
    ib = b;
    e.ovf = 1'b0;
    e.dz  = 1'b0;
    if (ib == 0) begin
      e.q = 16'hFFFF; e.r = a; e.dz = 1'b1;
    end else if (ia == -32768 && ib == -1) begin
      e.q = 16'h8000; e.r = 16'h0000; e.ovf = 1'b1;
    end else begin
      e.q = 16'(ia / ib);
      e.r = 16'(ia % ib);
    end
    return e;
  endfunction

  // Called #1 after the accepting edge; waits for done and scores the result.
  task automatic wait_done(input int exp_lat, input string tag);
    int   edges    = 0;
    int   busy_cyc = 1;
    exp_t e;
    while (done_out !== 1'b1 && edges < 100) begin
      @(posedge clock); #1;
      edges++;
      if (busy_out === 1'b1) busy_cyc++;
    end
    check({tag, "_latency"}, 32'(edges), 32'(exp_lat));
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_quot"}, 32'(quotient_out), 32'(e.q));
      check({tag, "_rem"},  32'(remainder_out), 32'(e.r));
      check({tag, "_ovf"},  32'(overflow_out), 32'(e.ovf));
      check({tag, "_dz"},   32'(div_by_zero_out), 32'(e.dz));
      @(posedge clock); #1;
      check({tag, "_busy_cycles"}, 32'(busy_cyc), 32'(exp_lat + 1));
      check({tag, "_busy_drop"}, 32'(busy_out), 32'd0);
      check({tag, "_done_pulse"}, 32'(done_out), 32'd0);
      check({tag, "_quot_hold"}, 32'(quotient_out), 32'(e.q));
    end
  endtask

  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit change, input string tag);
    @(negedge clock);
    dividend_in = a;
    divisor_in  = b;
    start_in    = 1'b1;
    sb.push_back(model(a, b));
    @(posedge clock); #1;
    check({tag, "_accept"}, 32'(busy_out), 32'd1);
    start_in = 1'b0;
    if (change) begin
      dividend_in = W'($urandom);
      divisor_in  = W'($urandom);
    end
    wait_done((b == '0) ? 2 : 18, tag);
  endtask

  logic [W-1:0] va[10];
  logic [W-1:0] vb[10];

  initial begin
    int done_seen;
    va = '{16'd100, 16'hFF9C, 16'd100, 16'hFF9C, 16'd1234, 16'h8000, 16'h8000, 16'd32767, 16'h8000, 16'd7};
    vb = '{16'd7,   16'd7,    16'hFFF9, 16'hFFF9, 16'd0,   16'hFFFF, 16'd1,   16'h8000,  16'd0,   16'd100};

    reset_in    = 1'b0;
    start_in    = 1'b0;
    dividend_in = '0;
    divisor_in  = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_quot", 32'(quotient_out), 32'd0);
    check("rst_rem",  32'(remainder_out), 32'd0);
    check("rst_busy", 32'(busy_out), 32'd0);
    check("rst_done", 32'(done_out), 32'd0);
    check("rst_ovf",  32'(overflow_out), 32'd0);
    check("rst_dz",   32'(div_by_zero_out), 32'd0);
    @(negedge clock);
    reset_in = 1'b1;

    for (int i = 0; i < 10; i++) do_div(va[i], vb[i], 1'b0, $sformatf("dir%0d", i));
    for (int i = 0; i < 8; i++)  do_div(W'($urandom), W'($urandom_range(0, 40)), 1'b1, $sformatf("rnd%0d", i));

    // start held high across an operation, operands changed while busy
    @(negedge clock);
    dividend_in = 16'd300;
    divisor_in  = 16'd17;
    start_in    = 1'b1;
    sb.push_back(model(16'd300, 16'd17));
    @(posedge clock); #1;
    dividend_in = 16'hFFB3;  // -77
    divisor_in  = 16'd3;
    wait_done(18, "hold1");
    @(posedge clock); #1;
    check("hold2_accept", 32'(busy_out), 32'd1);
    sb.push_back(model(16'hFFB3, 16'd3));
    start_in = 1'b0;
    wait_done(18, "hold2");

    // reset during iteration 5
    @(negedge clock);
    dividend_in = 16'd200;
    divisor_in  = 16'd9;
    start_in    = 1'b1;
    @(posedge clock); #1;
    start_in = 1'b0;
    repeat (6) @(posedge clock);
    #1;
    reset_in = 1'b0;
    #1;
    check("abort_quot", 32'(quotient_out), 32'd0);
    check("abort_rem",  32'(remainder_out), 32'd0);
    check("abort_busy", 32'(busy_out), 32'd0);
    check("abort_done", 32'(done_out), 32'd0);
    done_seen = 0;
    repeat (3) begin
      @(negedge clock);
      if (done_out === 1'b1) done_seen++;
    end
    reset_in = 1'b1;
    repeat (25) begin
      @(negedge clock);
      if (done_out === 1'b1) done_seen++;
    end
    check("abort_no_done", 32'(done_seen), 32'd0);
    check("abort_idle", 32'(busy_out), 32'd0);

    do_div(16'd50, 16'd5, 1'b0, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
